dvsd_count_monitor: RTL and testbench
=====================================

Name: dvsd_count_monitor

Overview:
- Downstream checker for the 4-bit up/down binary counter.
- Samples the counter output and the direction input the counter was driven with, and checks that each successive value is exactly the previous value plus or minus 1, modulo 2^WIDTH.
- Reports wrap events and sequence errors, keeps saturating statistics, and latches a fault state after repeated consecutive errors.
- Sits beside the counter in the top level and feeds status logic and the bench scoreboard.

Parameters:
- WIDTH, 4, width of the monitored count.
- STAT_W, 8, width of the wrap_count and err_count statistics counters.
- ERR_LIMIT, 3, number of consecutive mismatches that forces the FAULT state (legal range 1..7).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- count_valid  input  1  high while count_in is meaningful, i.e. the counter is out of its own reset.
- count_in  input  WIDTH  counter output.
- updown  input  1  direction presented to the counter this cycle; 1 = up, 0 = down.
- clr  input  1  synchronous clear of statistics, the sticky flag and FAULT.
- wrap_pulse  output  1  one-cycle pulse on a legal wrap (max to 0 going up, 0 to max going down).
- err_pulse  output  1  one-cycle pulse on a sequence mismatch.
- err_sticky  output  1  set by any mismatch; cleared by reset or clr.
- fault  output  1  high while in the FAULT state.
- wrap_count  output  STAT_W  saturating count of wraps.
- err_count  output  STAT_W  saturating count of mismatches.
- state  output  2  current FSM state, for debug.

Behaviour:
- Reset (reset = 0): state = IDLE; all outputs 0; prev_val = 0; prev_dir = 0; consec = 0. Effect is immediate (asynchronous); release is taken on a clock edge.
- Sampling: on each rising edge with count_valid = 1, capture prev_val <= count_in and prev_dir <= updown.
- Expected value: exp = prev_dir ? prev_val + 1 : prev_val - 1, computed in WIDTH bits with natural wrap. This matches the counter, whose next value depends on the direction at the previous edge.
- FSM states:
  - IDLE = 0: waiting for the first valid sample. When count_valid = 1, capture the sample and go to TRACK. No checks in IDLE.
  - TRACK = 1: on each valid cycle compare count_in with exp.
    - Match: consec <= 0. If prev_dir = 1, prev_val = max and count_in = 0, or prev_dir = 0, prev_val = 0 and count_in = max, then wrap_pulse = 1 and wrap_count increments.
    - Mismatch: err_pulse = 1, err_sticky <= 1, err_count increments, consec increments. When consec reaches ERR_LIMIT, go to FAULT.
    - The sample is always captured, so checking resynchronises to the new value.
  - FAULT = 2: fault = 1. No checks and no pulses; statistics frozen. Exit only via clr, which goes to IDLE.
- count_valid = 0 in any state other than FAULT: go to IDLE, consec <= 0, statistics kept. This covers the counter entering reset mid-run.
- clr = 1: wrap_count, err_count, err_sticky and consec go to 0, and the state goes to IDLE.
  - clr has priority over same-cycle pulses and increments; a mismatch in the clr cycle is discarded.
- Pulse timing: pulses are registered and appear in the cycle after the edge that sampled the offending or wrapping value (latency 1).
- Statistics saturate at 2^STAT_W - 1 and never wrap.
- State encoding 3 is unused; if reached, go to IDLE on the next edge.

Optional Feature:
- Macro: DVSD_MON_HOLD_EN.
- Defined: count_in == prev_val in TRACK counts as a legal hold. No error, no pulse, consec unchanged.
- Undefined: a hold is a mismatch like any other value.

Decomposition:
- Package dvsd_counter_pkg:
  - mon_state_t enum: IDLE = 2'd0, TRACK = 2'd1, FAULT = 2'd2.
  - Default constants CNT_WIDTH = 4 and STAT_WIDTH = 8.
- Sub-module dvsd_sat_counter: parameter W; inputs inc and clr; output the value; saturating. Instantiated twice, once for wraps and once for errors.

Test Plan:
- Reset, then count_valid = 1 with updown = 1 and count_in stepping 0..15, then 0: exactly one wrap_pulse (on 15 -> 0); wrap_count = 1; err_count = 0; state = TRACK.
- Hold updown = 0 with count_in stepping 3, 2, 1, 0, 15: one wrap_pulse, no errors.
- In TRACK, drive the sequence 5, 9, 2, 7: three err_pulses; err_count = 3; fault = 1 and state = FAULT one cycle after the third; then clr = 1 for one cycle → state = IDLE, counts 0, err_sticky = 0.
- Drop count_valid for 4 cycles mid-run, then resume at count_in = 0: state returns to IDLE and re-primes, with no error; prior wrap_count is retained.
- Drive count_in = 6, 6 in TRACK: one error without DVSD_MON_HOLD_EN; no error with the macro defined.
- Assert reset asynchronously between clock edges while in FAULT: all outputs go to 0 immediately, before the next edge.

Source files
------------

// File: rtl/dvsd_counter_pkg.sv
// Shared types and defaults for the up/down counter and its monitor.
// Optional feature macro used by the monitor: DVSD_MON_HOLD_EN.
package dvsd_counter_pkg;

    // Monitor FSM states; encoding 3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } mon_state_t;

    localparam int CNT_WIDTH  = 4;
    localparam int STAT_WIDTH = 8;

endpackage

// File: rtl/dvsd_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module dvsd_sat_counter
    import dvsd_counter_pkg::*;
#(
    parameter int W = STAT_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] value_q, value_d;

    // Next value: clear, otherwise increment unless already at all-ones.
    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i && (value_q != '1)) begin
            value_d = value_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/dvsd_count_monitor.sv
// Sequence checker for the up/down counter: verifies each valid sample is the
// previous sample +/- 1 (per the direction seen with the previous sample),
// flags wraps and errors, keeps saturating stats, latches FAULT after
// ERR_LIMIT consecutive errors.
// Optional macro DVSD_MON_HOLD_EN: a repeated value in TRACK is a legal hold.
module dvsd_count_monitor
    import dvsd_counter_pkg::*;
#(
    parameter int WIDTH     = CNT_WIDTH,
    parameter int STAT_W    = STAT_WIDTH,
    parameter int ERR_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              count_valid,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              updown,
    input  logic              clr,
    output logic              wrap_pulse,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic              fault,
    output logic [STAT_W-1:0] wrap_count,
    output logic [STAT_W-1:0] err_count,
    output logic [1:0]        state
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] VMAX = '1;

    mon_state_t       state_q, state_d;
    logic [WIDTH-1:0] prev_val_q, prev_val_d;
    logic             prev_dir_q, prev_dir_d;
    logic [2:0]       consec_q, consec_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic             err_pulse_q, err_pulse_d;
    logic             sticky_q, sticky_d;
    logic             wrap_inc, err_inc;

    logic [WIDTH-1:0] exp_val;
    logic             is_match, is_wrap, is_hold;

    // Expected sample and classification of the current sample.
    always_comb begin
        exp_val  = prev_dir_q ? (prev_val_q + ONE) : (prev_val_q - ONE);
        is_match = (count_in == exp_val);
        // A match from the boundary value in the travel direction is a wrap.
        is_wrap  = is_match && (prev_dir_q ? (prev_val_q == VMAX) : (prev_val_q == '0));
`ifdef DVSD_MON_HOLD_EN
        is_hold  = (count_in == prev_val_q);
`else
        is_hold  = 1'b0;
`endif
    end

    // FSM next state, sample capture, pulses and stat increments.
    always_comb begin
        state_d      = state_q;
        prev_val_d   = prev_val_q;
        prev_dir_d   = prev_dir_q;
        consec_d     = consec_q;
        wrap_pulse_d = 1'b0;
        err_pulse_d  = 1'b0;
        sticky_d     = sticky_q;
        wrap_inc     = 1'b0;
        err_inc      = 1'b0;

        // Every valid sample is captured so checking resyncs after an error.
        if (count_valid) begin
            prev_val_d = count_in;
            prev_dir_d = updown;
        end

        case (state_q)
            IDLE: begin
                consec_d = '0;
                if (count_valid) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (!count_valid) begin
                    state_d  = IDLE;
                    consec_d = '0;
                end else if (is_hold) begin
                    // Legal hold: nothing to report, streak untouched.
                end else if (is_match) begin
                    consec_d = '0;
                    if (is_wrap) begin
                        wrap_pulse_d = 1'b1;
                        wrap_inc     = 1'b1;
                    end
                end else begin
                    err_pulse_d = 1'b1;
                    sticky_d    = 1'b1;
                    err_inc     = 1'b1;
                    consec_d    = consec_q + 3'd1;
                    if (int'(consec_q) + 1 >= ERR_LIMIT) begin
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                // Frozen until clr.
            end
            default: begin
                state_d  = IDLE;
                consec_d = '0;
            end
        endcase

        // Clear overrides everything decided above in this cycle.
        if (clr) begin
            state_d      = IDLE;
            consec_d     = '0;
            sticky_d     = 1'b0;
            wrap_pulse_d = 1'b0;
            err_pulse_d  = 1'b0;
            wrap_inc     = 1'b0;
            err_inc      = 1'b0;
        end
    end

    // Monitor state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            prev_val_q   <= '0;
            prev_dir_q   <= 1'b0;
            consec_q     <= '0;
            wrap_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_val_q   <= prev_val_d;
            prev_dir_q   <= prev_dir_d;
            consec_q     <= consec_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_pulse_q  <= err_pulse_d;
            sticky_q     <= sticky_d;
        end
    end

    dvsd_sat_counter #(.W(STAT_W)) u_wrap_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .inc_i   (wrap_inc),
        .clr_i   (clr),
        .value_o (wrap_count)
    );

    dvsd_sat_counter #(.W(STAT_W)) u_err_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .inc_i   (err_inc),
        .clr_i   (clr),
        .value_o (err_count)
    );

    assign wrap_pulse = wrap_pulse_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = sticky_q;
    assign fault      = (state_q == FAULT);
    assign state      = state_q;

endmodule

// File: tb/tb_dvsd_count_monitor.sv
// Self-checking bench for dvsd_count_monitor: directed scenarios plus a
// randomized run against a behavioural model of the sequence rules.
module tb_dvsd_count_monitor;

`ifdef DVSD_MON_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk, reset, count_valid, updown, clr;
    logic [3:0] count_in;
    logic       wrap_pulse, err_pulse, err_sticky, fault;
    logic [7:0] wrap_count, err_count;
    logic [1:0] state;

    int n_pass, n_total;

    // Behavioural model
    bit m_primed, m_fault, m_dir, m_sticky, m_wp, m_ep;
    int m_prev, m_consec, m_wraps, m_errs;

    dvsd_count_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .count_valid (count_valid),
        .count_in    (count_in),
        .updown      (updown),
        .clr         (clr),
        .wrap_pulse  (wrap_pulse),
        .err_pulse   (err_pulse),
        .err_sticky  (err_sticky),
        .fault       (fault),
        .wrap_count  (wrap_count),
        .err_count   (err_count),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_primed = 0; m_fault = 0; m_dir = 0; m_sticky = 0; m_wp = 0; m_ep = 0;
        m_prev = 0; m_consec = 0; m_wraps = 0; m_errs = 0;
    endtask

    task automatic model_step(input bit v, input int val, input bit d, input bit cl);
        int expv;
        m_wp = 0;
        m_ep = 0;
        if (cl) begin
            m_primed = 0; m_fault = 0; m_consec = 0;
            m_wraps = 0; m_errs = 0; m_sticky = 0;
        end else if (m_fault) begin
        end else if (!v) begin
            m_primed = 0;
            m_consec = 0;
        end else if (!m_primed) begin
            m_primed = 1;
        end else begin
            expv = (m_prev + (m_dir ? 1 : 15)) % 16;
            if (HOLD_EN && val == m_prev) begin
            end else if (val == expv) begin
                m_consec = 0;
                if ((m_dir && m_prev == 15) || (!m_dir && m_prev == 0)) begin
                    m_wp = 1;
                    if (m_wraps < 255) m_wraps++;
                end
            end else begin
                m_ep = 1;
                m_sticky = 1;
                if (m_errs < 255) m_errs++;
                m_consec++;
                if (m_consec >= 3) m_fault = 1;
            end
        end
        if (v) begin
            m_prev = val;
            m_dir = d;
        end
    endtask

    function automatic logic [21:0] model_vec();
        logic [1:0] st;
        st = m_fault ? 2'd2 : (m_primed ? 2'd1 : 2'd0);
        return {m_wp, m_ep, m_sticky, m_fault, st, 8'(m_wraps), 8'(m_errs)};
    endfunction

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input bit v, input logic [3:0] c, input bit d, input bit cl);
        count_valid = v;
        count_in    = c;
        updown      = d;
        clr         = cl;
        @(posedge clk);
        model_step(v, int'(c), d, cl);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        reset = 1'b0; count_valid = 0; count_in = 4'd7; updown = 1; clr = 0;
        model_reset();
        #1;
        obs = {wrap_pulse, err_pulse, err_sticky, fault, state, wrap_count, err_count};
        n_total++;
        if (obs !== 22'd0) $display("FAIL reset_outputs got=%h want=0", obs);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        n_total++;
        if (state !== 2'd0) $display("FAIL reset_release_state got=%0d want=0", state);
        else n_pass++;
    endtask

    task automatic test_up_wrap();
        int wp;
        wp = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 4'(i), 1, 0);
            wp += int'(wrap_pulse);
        end
        step(1, 4'd0, 1, 0);
        n_total++;
        if (wrap_pulse !== 1'b1) $display("FAIL up_wrap_pulse_at_15_0 got=%b want=1", wrap_pulse);
        else n_pass++;
        wp += int'(wrap_pulse);
        n_total++;
        if (wp != 1 || wrap_count !== 8'd1 || err_count !== 8'd0 || state !== 2'd1)
            $display("FAIL up_wrap got pulses=%0d wc=%0d ec=%0d st=%0d want 1/1/0/1",
                     wp, wrap_count, err_count, state);
        else n_pass++;
    endtask

    task automatic test_down_wrap();
        int wp, ep;
        logic [3:0] seq [5];
        seq = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15};
        wp = 0; ep = 0;
        step(0, 4'd0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, seq[i], 0, 0);
            wp += int'(wrap_pulse);
            ep += int'(err_pulse);
        end
        n_total++;
        if (wp != 1 || ep != 0 || wrap_count !== 8'd1 || err_count !== 8'd0)
            $display("FAIL down_wrap got pulses=%0d errs=%0d wc=%0d ec=%0d want 1/0/1/0",
                     wp, ep, wrap_count, err_count);
        else n_pass++;
    endtask

    task automatic test_errors_fault();
        int ep;
        ep = 0;
        step(1, 4'd5, 1, 0); ep += int'(err_pulse);
        step(1, 4'd9, 1, 0); ep += int'(err_pulse);
        n_total++;
        if (fault !== 1'b0 || state !== 2'd1)
            $display("FAIL fault_early got fault=%b st=%0d want 0/1", fault, state);
        else n_pass++;
        step(1, 4'd2, 1, 0); ep += int'(err_pulse);
        n_total++;
        if (ep != 3 || err_count !== 8'd3 || fault !== 1'b1 || state !== 2'd2 || err_sticky !== 1'b1)
            $display("FAIL errors_to_fault got errs=%0d ec=%0d fault=%b st=%0d sticky=%b want 3/3/1/2/1",
                     ep, err_count, fault, state, err_sticky);
        else n_pass++;
        step(1, 4'd7, 1, 0);
        n_total++;
        if (err_pulse !== 1'b0 || err_count !== 8'd3 || state !== 2'd2)
            $display("FAIL fault_frozen got ep=%b ec=%0d st=%0d want 0/3/2", err_pulse, err_count, state);
        else n_pass++;
        step(1, 4'd8, 1, 1);
        n_total++;
        if (state !== 2'd0 || err_count !== 8'd0 || wrap_count !== 8'd0 || err_sticky !== 1'b0 || fault !== 1'b0)
            $display("FAIL clr_exit got st=%0d ec=%0d wc=%0d sticky=%b fault=%b want all 0",
                     state, err_count, wrap_count, err_sticky, fault);
        else n_pass++;
    endtask

    task automatic test_valid_drop();
        int ep;
        ep = 0;
        step(0, 4'd0, 1, 0);
        for (int i = 0; i < 16; i++) step(1, 4'(i), 1, 0);
        step(1, 4'd0, 1, 0);
        step(1, 4'd1, 1, 0);
        step(1, 4'd2, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'($urandom_range(0, 15)), 1, 0);
            if (i == 0) begin
                n_total++;
                if (state !== 2'd0) $display("FAIL drop_to_idle got st=%0d want 0", state);
                else n_pass++;
            end
        end
        step(1, 4'd0, 1, 0); ep += int'(err_pulse);
        n_total++;
        if (state !== 2'd1) $display("FAIL reprime_state got st=%0d want 1", state);
        else n_pass++;
        step(1, 4'd1, 1, 0); ep += int'(err_pulse);
        step(1, 4'd2, 1, 0); ep += int'(err_pulse);
        n_total++;
        if (ep != 0 || err_count !== 8'd0 || wrap_count !== 8'd1)
            $display("FAIL resume_after_drop got errs=%0d ec=%0d wc=%0d want 0/0/1", ep, err_count, wrap_count);
        else n_pass++;
    endtask

    task automatic test_hold();
        int ep, want;
        ep = 0;
        want = HOLD_EN ? 0 : 1;
        step(1, 4'd3, 1, 0); ep += int'(err_pulse);
        step(1, 4'd4, 1, 0); ep += int'(err_pulse);
        step(1, 4'd5, 1, 0); ep += int'(err_pulse);
        step(1, 4'd6, 1, 0); ep += int'(err_pulse);
        step(1, 4'd6, 1, 0); ep += int'(err_pulse);
        step(1, 4'd7, 1, 0); ep += int'(err_pulse);
        n_total++;
        if (ep != want || err_count !== 8'(want) || state !== 2'd1)
            $display("FAIL hold got errs=%0d ec=%0d st=%0d want %0d/%0d/1", ep, err_count, state, want, want);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]  nxt, v;
        logic [21:0] obs, expv;
        bit          d, vl, cl;
        nxt = 4'd8;
        d = 1'b1;
        for (int i = 0; i < 400; i++) begin
            vl = ($urandom_range(0, 15) != 0);
            cl = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) d = !d;
            case ($urandom_range(0, 19))
                0:       v = 4'($urandom_range(0, 15));
                1:       v = nxt + 4'd7;
                default: v = nxt;
            endcase
            step(vl, v, d, cl);
            nxt = d ? v + 4'd1 : v - 4'd1;
            obs  = {wrap_pulse, err_pulse, err_sticky, fault, state, wrap_count, err_count};
            expv = model_vec();
            n_total++;
            if (obs !== expv) $display("FAIL random cycle=%0d got=%h want=%h", i, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        step(0, 4'd0, 1, 1);
        for (int i = 0; i < 16 * 260 + 1; i++) step(1, 4'(i % 16), 1, 0);
        n_total++;
        if (wrap_count !== 8'd255 || err_count !== 8'd0)
            $display("FAIL wrap_saturate got wc=%0d ec=%0d want 255/0", wrap_count, err_count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [21:0] obs;
        step(0, 4'd0, 1, 1);
        step(1, 4'd0, 1, 0);
        step(1, 4'd5, 1, 0);
        step(1, 4'd9, 1, 0);
        step(1, 4'd2, 1, 0);
        n_total++;
        if (fault !== 1'b1) $display("FAIL async_pre_fault got fault=%b want 1", fault);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        obs = {wrap_pulse, err_pulse, err_sticky, fault, state, wrap_count, err_count};
        n_total++;
        if (obs !== 22'd0) $display("FAIL async_reset_immediate got=%h want=0", obs);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        count_valid = 0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_errors_fault();
        test_valid_drop();
        test_hold();
        test_random();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
